comp_split_1to4: RTL and testbench
==================================

COMP_SPLIT_1TO4 -- requirements
Module: comp_split_1to4

Interface
REQ-001 SHALL have parameter: WIDTH, 16, bit width of every data word.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: clear  input  1  synchronous flush of a partial group.
REQ-005 SHALL have port: in_val  input  WIDTH  serial data word.
REQ-006 SHALL have port: in_valid  input  1  in_val is valid this cycle.
REQ-007 SHALL have port: in_ready  output  1  block accepts in_val this cycle.
REQ-008 SHALL have port: val1, val2, val3, val4  output  WIDTH each  parallel operands for the 4-to-1 summer.
REQ-009 SHALL have port: out_valid  output  1  val1..val4 hold a complete group.
REQ-010 SHALL have port: out_ready  input  1  downstream consumes the group this cycle.
REQ-011 SHALL have port: count  output  2  number of words stored in the current partial group.

Function
REQ-012 SHALL accept a word only on the cycle where in_valid and in_ready are both 1 (input handshake).
REQ-013 SHALL release a group only on the cycle where out_valid and out_ready are both 1 (output handshake).
REQ-014 SHALL implement a two-state FSM: FILL and FULL.
REQ-015 In FILL, SHALL drive in_ready=1 and out_valid=0.
REQ-016 In FILL, SHALL write each accepted word to slot count (0->val1, 1->val2, 2->val3, 3->val4) and then increment count.
REQ-017 On acceptance of the 4th word (count=3), SHALL wrap count to 0 and enter FULL; out_valid SHALL rise on the next cycle, one cycle after that word.
REQ-018 In FULL, SHALL hold out_valid=1 and val1..val4 stable until the output handshake.
REQ-019 In FULL, SHALL drive in_ready = out_ready (combinational).
REQ-020 In FULL, output handshake with no input handshake SHALL return the FSM to FILL with count=0.
REQ-021 In FULL, simultaneous output and input handshakes SHALL write the new word to val1, set count=1 and enter FILL; no bubble is allowed.
REQ-022 Words in slots not yet rewritten SHALL retain old values; downstream SHALL use them only while out_valid=1.
REQ-023 clear=1 in FILL SHALL set count=0, discard the partial group and ignore any in_val that cycle; in_ready SHALL stay 1.
REQ-024 clear=1 in FULL SHALL be ignored; the complete group is preserved.
REQ-025 SHALL perform no arithmetic on data; words SHALL pass bit-exact.
REQ-026 count SHALL wrap modulo 4 and never exceed 3.

Reset
REQ-027 While reset=1, SHALL force state=FILL, count=0, val1..val4=0, out_valid=0 and in_ready=0, independent of clk.
REQ-028 On the first rising clk edge after reset deasserts, SHALL drive in_ready=1.
REQ-029 Reset asserted mid-group or in FULL SHALL drop all stored data with no pending out_valid.

Structure
REQ-030 Shared package comp_pkg SHALL hold the WIDTH default constant and the FSM state enum (FILL, FULL).
REQ-031 SHALL be a single module with no sub-modules; the four slot registers and the FSM live in one file.
REQ-032 Outputs val1..val4 and out_valid SHALL be driven directly from registers; in_ready is the only combinational output.

Verification
REQ-033 Reset, then feed 0x0001, 0x0002, 0x0003, 0x0004 back-to-back with out_ready=0 -> out_valid=1 one cycle after the 4th word; val1..val4=1,2,3,4; in_ready=0; state held for 10 cycles.
REQ-034 From FULL, assert out_ready=1 and in_valid=1 with 0xAAAA -> same-cycle release; val1=0xAAAA; count=1; out_valid=0 next cycle.
REQ-035 Feed 0x1111 and 0x2222, then clear=1 with in_valid=1 and 0x3333 -> count=0; 0x3333 dropped; the next four words 5,6,7,8 appear as val1..val4=5,6,7,8.
REQ-036 Pulse clear=1 while in FULL -> out_valid stays 1; val1..val4 unchanged.
REQ-037 Assert reset asynchronously between clk edges with count=2 -> out_valid=0, count=0, val1..val4=0 immediately; in_ready=1 after the first clk edge post-release.
REQ-038 Random in_valid/out_ready stress with 0xFFFF words; a scoreboard sums each group -> every group delivered exactly once, in order, bit-exact; count never exceeds 3.

Source files
------------

// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared constants and FSM state type for the 1-to-4 operand splitter
package comp_pkg;

   localparam int WIDTH_DEFAULT = 16;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

endpackage

// File: rtl/comp_split_1to4.sv
// rtl/comp_split_1to4.sv - collects four serial words into one parallel group for a 4-to-1 summer
module comp_split_1to4
   import comp_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] in_val,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] val1,
   output logic [WIDTH-1:0] val2,
   output logic [WIDTH-1:0] val3,
   output logic [WIDTH-1:0] val4,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       count
);

   state_e           state_q, state_d;
   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] slot_q [4];
   logic [WIDTH-1:0] slot_d [4];
   logic             out_valid_q, out_valid_d;
   // live_q holds in_ready low through reset and until the first edge after release
   logic             live_q;
   logic             accept;
   logic             release_grp;

   assign in_ready    = live_q & ((state_q == FILL) | out_ready);
   assign accept      = in_valid & in_ready;
   assign release_grp = out_valid_q & out_ready;

   assign val1      = slot_q[0];
   assign val2      = slot_q[1];
   assign val3      = slot_q[2];
   assign val4      = slot_q[3];
   assign out_valid = out_valid_q;
   assign count     = count_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      slot_d      = slot_q;
      out_valid_d = out_valid_q;
      case (state_q)
         FILL: begin
            if (clear) begin
               count_d = 2'd0;
            end else if (accept) begin
               slot_d[count_q] = in_val;
               if (count_q == 2'd3) begin
                  count_d     = 2'd0;
                  state_d     = FULL;
                  out_valid_d = 1'b1;
               end else begin
                  count_d = count_q + 2'd1;
               end
            end
         end
         FULL: begin
            // a word arriving with the release starts the next group without a bubble
            if (release_grp) begin
               state_d     = FILL;
               out_valid_d = 1'b0;
               if (accept) begin
                  slot_d[0] = in_val;
                  count_d   = 2'd1;
               end else begin
                  count_d = 2'd0;
               end
            end
         end
         default: begin
            state_d     = FILL;
            count_d     = 2'd0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FILL;
         count_q     <= 2'd0;
         out_valid_q <= 1'b0;
         live_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         live_q      <= 1'b1;
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

endmodule

// File: tb/tb_comp_split_1to4.sv
// tb/tb_comp_split_1to4.sv - self-checking bench for comp_split_1to4 with a queue-based model
module tb_comp_split_1to4;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         clear = 1'b0;
   logic [W-1:0] in_val = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] val1, val2, val3, val4;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [1:0]   count;

   int tests  = 0;
   int errors = 0;

   comp_split_1to4 #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_val    (in_val),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .val1      (val1),
      .val2      (val2),
      .val3      (val3),
      .val4      (val4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: words accepted since the last flush wait in a queue; four of them become a group.
   logic [W-1:0] m_part[$];
   logic [W-1:0] m_grp[4];
   bit           m_full    = 1'b0;
   bit           m_started = 1'b0;
   int           m_deliv   = 0;
   int           dut_rel   = 0;

   function automatic bit m_ready();
      return !reset && m_started && (!m_full || out_ready);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_part.delete();
         m_full    = 1'b0;
         m_started = 1'b0;
         for (int i = 0; i < 4; i++) m_grp[i] = '0;
      end else begin
         automatic bit acc = in_valid && m_ready();
         automatic bit rel = m_full && out_ready;
         if (out_valid && out_ready) dut_rel++;
         if (!m_full) begin
            if (clear) begin
               m_part.delete();
            end else if (acc) begin
               m_part.push_back(in_val);
               if (m_part.size() == 4) begin
                  for (int i = 0; i < 4; i++) m_grp[i] = m_part[i];
                  m_part.delete();
                  m_full = 1'b1;
               end
            end
         end else if (rel) begin
            automatic int es = int'(m_grp[0]) + int'(m_grp[1]) + int'(m_grp[2]) + int'(m_grp[3]);
            automatic int ds = int'(val1) + int'(val2) + int'(val3) + int'(val4);
            check("group_sum", ds, es);
            m_deliv++;
            m_full = 1'b0;
            if (acc) m_part.push_back(in_val);
         end
         m_started = 1'b1;
      end
   end

   always @(negedge clk) begin
      check("cmp_in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      check("cmp_out_valid", {31'd0, out_valid}, {31'd0, m_full});
      check("cmp_count", {30'd0, count}, m_part.size());
      if (m_full) begin
         check("cmp_val1", {16'd0, val1}, {16'd0, m_grp[0]});
         check("cmp_val2", {16'd0, val2}, {16'd0, m_grp[1]});
         check("cmp_val3", {16'd0, val3}, {16'd0, m_grp[2]});
         check("cmp_val4", {16'd0, val4}, {16'd0, m_grp[3]});
      end
   end

   task automatic drive(input bit v, input logic [W-1:0] w, input bit ordy, input bit clr);
      in_valid  = v;
      in_val    = w;
      out_ready = ordy;
      clear     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_group(input string name, input logic [W-1:0] a, b, c, d);
      check({name, "_v1"}, {16'd0, val1}, {16'd0, a});
      check({name, "_v2"}, {16'd0, val2}, {16'd0, b});
      check({name, "_v3"}, {16'd0, val3}, {16'd0, c});
      check({name, "_v4"}, {16'd0, val4}, {16'd0, d});
   endtask

   initial begin
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_count", {30'd0, count}, 32'd0);
      check_group("rst", 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      drive(0, 16'h0, 0, 0);
      check("first_in_ready", {31'd0, in_ready}, 32'd1);

      drive(1, 16'h0001, 0, 0);
      drive(1, 16'h0002, 0, 0);
      drive(1, 16'h0003, 0, 0);
      check("pre_full_valid", {31'd0, out_valid}, 32'd0);
      drive(1, 16'h0004, 0, 0);
      in_valid = 1'b0;
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check_group("full", 16'h1, 16'h2, 16'h3, 16'h4);
      repeat (10) drive(1, 16'hBEEF, 0, 0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check_group("hold", 16'h1, 16'h2, 16'h3, 16'h4);

      drive(0, 16'h0, 0, 1);
      check("clr_full_valid", {31'd0, out_valid}, 32'd1);
      check_group("clr_full", 16'h1, 16'h2, 16'h3, 16'h4);

      drive(1, 16'hAAAA, 1, 0);
      check("pass_out_valid", {31'd0, out_valid}, 32'd0);
      check("pass_count", {30'd0, count}, 32'd1);
      check("pass_val1", {16'd0, val1}, 32'hAAAA);

      drive(1, 16'h1111, 0, 0);
      drive(1, 16'h2222, 0, 0);
      check("pre_clr_count", {30'd0, count}, 32'd3);
      drive(1, 16'h3333, 0, 1);
      check("clr_count", {30'd0, count}, 32'd0);
      check("clr_out_valid", {31'd0, out_valid}, 32'd0);
      drive(1, 16'h0005, 0, 0);
      drive(1, 16'h0006, 0, 0);
      drive(1, 16'h0007, 0, 0);
      drive(1, 16'h0008, 0, 0);
      check("after_clr_valid", {31'd0, out_valid}, 32'd1);
      check_group("after_clr", 16'h5, 16'h6, 16'h7, 16'h8);
      drive(0, 16'h0, 1, 0);
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      drive(1, 16'h00C1, 0, 0);
      drive(1, 16'h00C2, 0, 0);
      in_valid = 1'b0;
      check("mid_count", {30'd0, count}, 32'd2);
      #3 reset = 1'b1;
      #1;
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_count", {30'd0, count}, 32'd0);
      check("async_in_ready", {31'd0, in_ready}, 32'd0);
      check_group("async", 16'h0, 16'h0, 16'h0, 16'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      drive(0, 16'h0, 0, 0);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 600; i++) begin
         automatic logic [W-1:0] w = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
         drive(bit'($urandom_range(0, 1)), w, bit'($urandom_range(0, 1)),
               ($urandom_range(0, 19) == 0));
      end
      repeat (3) drive(0, 16'h0, 1, 0);
      check("release_count", dut_rel, m_deliv);
      check("some_groups", {31'd0, m_deliv > 20}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
